// File: rtl/row_perm_pkg.sv
// row_perm_pkg: shared definitions for the row permuter.
//   row_w / mode_w   : index widths derived from N_ROWS / N_MODES
//   row_idx_t        : generic row index, wide enough for any supported N_ROWS
//   default_perm()   : reset contents of the permutation table
package row_perm_pkg;

  localparam int unsigned MAX_ROW_W = 8;

  typedef logic [MAX_ROW_W-1:0] row_idx_t;

  // Built-in 4-row table, 2 bits per entry at [(mode*4+row)*2 +: 2].
  // Row 0 sits in the low bits of each mode group.
  //   mode0 {2,1,0,3}  mode1 {0,3,2,1}  mode2 {1,0,3,2}  mode3 {3,2,1,0}
  localparam logic [31:0] DEF4_TABLE = {
    2'd0, 2'd1, 2'd2, 2'd3,   // mode3, rows 3..0
    2'd2, 2'd3, 2'd0, 2'd1,   // mode2
    2'd1, 2'd2, 2'd3, 2'd0,   // mode1
    2'd3, 2'd0, 2'd1, 2'd2    // mode0
  };

  function automatic int unsigned row_w(input int unsigned n_rows);
    return (n_rows <= 1) ? 1 : $clog2(n_rows);
  endfunction

  function automatic int unsigned mode_w(input int unsigned n_modes);
    return (n_modes <= 1) ? 1 : $clog2(n_modes);
  endfunction

  // Source row for (mode, row) after reset; identity outside the 4-row table.
  function automatic row_idx_t default_perm(input int unsigned mode,
                                            input int unsigned row,
                                            input int unsigned n_rows);
    row_idx_t v;
    v = '0;
    if (n_rows == 4 && mode < 4 && row < 4) begin
      v[1:0] = DEF4_TABLE[(mode*4 + row)*2 +: 2];
    end else begin
      v = row_idx_t'(row);
    end
    return v;
  endfunction

endpackage

// File: rtl/row_perm_table.sv
// row_perm_table: runtime-programmable permutation table.
//   clk, rst          : clock, async active-high reset (reloads defaults)
//   we/wr_mode/wr_row/wr_src : write table[wr_mode][wr_row] = wr_src
//   wr_err            : combinational pulse, write strobed with an out-of-range field
//   rd_mode           : mode to read
//   rd_sel            : source row per output row, row r at [r*ROW_W +: ROW_W]
//   rd_err            : rd_mode out of range (rd_sel then holds identity)
module row_perm_table
  import row_perm_pkg::*;
#(
  parameter  int unsigned N_ROWS  = 4,
  parameter  int unsigned N_MODES = 4,
  localparam int unsigned ROW_W   = row_w(N_ROWS),
  localparam int unsigned MODE_W  = mode_w(N_MODES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [MODE_W-1:0]       wr_mode,
  input  logic [ROW_W-1:0]        wr_row,
  input  logic [ROW_W-1:0]        wr_src,
  output logic                    wr_err,
  input  logic [MODE_W-1:0]       rd_mode,
  output logic [N_ROWS*ROW_W-1:0] rd_sel,
  output logic                    rd_err
);

  logic [ROW_W-1:0] tbl [N_MODES][N_ROWS];

  always_comb begin
    wr_err = we && ((32'(wr_mode) >= N_MODES) ||
                    (32'(wr_row)  >= N_ROWS)  ||
                    (32'(wr_src)  >= N_ROWS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned m = 0; m < N_MODES; m++) begin
        for (int unsigned r = 0; r < N_ROWS; r++) begin
          tbl[MODE_W'(m)][ROW_W'(r)] <= ROW_W'(default_perm(m, r, N_ROWS));
        end
      end
    end else if (we && !wr_err) begin
      tbl[wr_mode][wr_row] <= wr_src;
    end
  end

  always_comb begin
    rd_err = (32'(rd_mode) >= N_MODES);
    rd_sel = '0;
    for (int unsigned r = 0; r < N_ROWS; r++) begin
      if (rd_err) begin
        rd_sel[r*ROW_W +: ROW_W] = ROW_W'(r);
      end else begin
        rd_sel[r*ROW_W +: ROW_W] = tbl[rd_mode][ROW_W'(r)];
      end
    end
  end

endmodule

// File: rtl/row_permuter.sv
// row_permuter: registered row permuter for the cipher datapath.
// Reorders whole rows of an N_ROWS x N_COLS matrix of W-bit elements using a
// per-beat mode that selects an entry of a programmable permutation table.
//   clk, rst                 : clock, async active-high reset
//   in_valid/in_ready        : input handshake (in_ready = !out_valid || out_ready)
//   in_data, in_mode         : matrix (row r, col c at [(r*N_COLS+c)*W +: W]) and mode
//   out_valid/out_ready      : output handshake, one register stage
//   out_data, out_mode       : permuted matrix and the mode used
//   cfg_we/cfg_mode/cfg_row/cfg_src : table write port
//   cfg_err, cfg_err_clr     : sticky error flag and its clear
//   xfer_cnt                 : accepted input beats, wrapping
// Optional build macro ROW_PERMUTER_INVERSE_EN adds in_inv/out_inv; in_inv=1
// scatters rows through the inverse map (highest source row wins, unwritten rows 0).
module row_permuter
  import row_perm_pkg::*;
#(
  parameter  int unsigned W       = 8,
  parameter  int unsigned N_ROWS  = 4,
  parameter  int unsigned N_COLS  = 4,
  parameter  int unsigned N_MODES = 4,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned MODE_W  = mode_w(N_MODES),
  localparam int unsigned ROW_W   = row_w(N_ROWS),
  localparam int unsigned DATA_W  = N_ROWS*N_COLS*W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [MODE_W-1:0] in_mode,
`ifdef ROW_PERMUTER_INVERSE_EN
  input  logic              in_inv,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [MODE_W-1:0] out_mode,
`ifdef ROW_PERMUTER_INVERSE_EN
  output logic              out_inv,
`endif
  input  logic              cfg_we,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [ROW_W-1:0]  cfg_row,
  input  logic [ROW_W-1:0]  cfg_src,
  output logic              cfg_err,
  input  logic              cfg_err_clr,
  output logic [CNT_W-1:0]  xfer_cnt
);

  localparam int unsigned RB = N_COLS*W;  // bits per row

  logic [N_ROWS*ROW_W-1:0] sel;
  logic                    mode_bad;
  logic                    wr_err;
  logic                    accept;
  logic [DATA_W-1:0]       perm;

  row_perm_table #(
    .N_ROWS  (N_ROWS),
    .N_MODES (N_MODES)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (cfg_we),
    .wr_mode (cfg_mode),
    .wr_row  (cfg_row),
    .wr_src  (cfg_src),
    .wr_err  (wr_err),
    .rd_mode (in_mode),
    .rd_sel  (sel),
    .rd_err  (mode_bad)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Table reads are combinational, so a beat accepted alongside a table write
  // sees the pre-write entry.
  always_comb begin
    perm = '0;
    for (int unsigned r = 0; r < N_ROWS; r++) begin
      for (int unsigned s = 0; s < N_ROWS; s++) begin
`ifdef ROW_PERMUTER_INVERSE_EN
        if (in_inv) begin
          // ascending r: a later source overwrites an earlier duplicate
          if (32'(sel[r*ROW_W +: ROW_W]) == s) begin
            perm[s*RB +: RB] = in_data[r*RB +: RB];
          end
        end else
`endif
        if (32'(sel[r*ROW_W +: ROW_W]) == s) begin
          perm[r*RB +: RB] = in_data[s*RB +: RB];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= '0;
`ifdef ROW_PERMUTER_INVERSE_EN
      out_inv   <= 1'b0;
`endif
      cfg_err   <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= perm;
        out_mode  <= in_mode;
`ifdef ROW_PERMUTER_INVERSE_EN
        out_inv   <= in_inv;
`endif
        xfer_cnt  <= xfer_cnt + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // a new error event takes priority over a simultaneous clear
      if (wr_err || (accept && mode_bad)) begin
        cfg_err <= 1'b1;
      end else if (cfg_err_clr) begin
        cfg_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_row_permuter.sv
`timescale 1ns/1ps
module tb_row_permuter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // main instance: default parameters
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, out_data;
  logic [1:0]   in_mode, out_mode, cfg_mode, cfg_row, cfg_src;
  logic         cfg_we, cfg_err, cfg_err_clr;
  logic [15:0]  xfer_cnt;
  logic         inv_drv;
`ifdef ROW_PERMUTER_INVERSE_EN
  logic         in_inv, out_inv;
  assign in_inv = inv_drv;
`endif

  // error instance: 3 rows x 1 col, 3 modes, 4-bit counter (out-of-range codes reachable)
  logic        e_in_valid, e_in_ready, e_out_valid;
  logic        e_out_ready;
  logic [23:0] e_in_data, e_out_data;
  logic [1:0]  e_in_mode, e_out_mode, e_cfg_mode, e_cfg_row, e_cfg_src;
  logic        e_cfg_we, e_cfg_err, e_cfg_err_clr;
  logic [3:0]  e_xfer_cnt;
`ifdef ROW_PERMUTER_INVERSE_EN
  logic        e_out_inv;
  logic        e_in_inv;
  assign e_in_inv = 1'b0;
`endif

  row_permuter dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
`ifdef ROW_PERMUTER_INVERSE_EN
    .in_inv(in_inv),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
`ifdef ROW_PERMUTER_INVERSE_EN
    .out_inv(out_inv),
`endif
    .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_row(cfg_row), .cfg_src(cfg_src),
    .cfg_err(cfg_err), .cfg_err_clr(cfg_err_clr), .xfer_cnt(xfer_cnt)
  );

  row_permuter #(.W(8), .N_ROWS(3), .N_COLS(1), .N_MODES(3), .CNT_W(4)) edut (
    .clk(clk), .rst(rst),
    .in_valid(e_in_valid), .in_ready(e_in_ready), .in_data(e_in_data), .in_mode(e_in_mode),
`ifdef ROW_PERMUTER_INVERSE_EN
    .in_inv(e_in_inv),
`endif
    .out_valid(e_out_valid), .out_ready(e_out_ready), .out_data(e_out_data), .out_mode(e_out_mode),
`ifdef ROW_PERMUTER_INVERSE_EN
    .out_inv(e_out_inv),
`endif
    .cfg_we(e_cfg_we), .cfg_mode(e_cfg_mode), .cfg_row(e_cfg_row), .cfg_src(e_cfg_src),
    .cfg_err(e_cfg_err), .cfg_err_clr(e_cfg_err_clr), .xfer_cnt(e_xfer_cnt)
  );

  // ---------------- reference model ----------------
  int tbl  [4][4];
  int etbl [3][3];
  int exp_cnt;
  int e_cnt;

  localparam logic [31:0] R0 = 32'h00010203;
  localparam logic [31:0] R1 = 32'h10111213;
  localparam logic [31:0] R2 = 32'h20212223;
  localparam logic [31:0] R3 = 32'h30313233;
  logic [127:0] rmat;

  task automatic model_reset;
    tbl[0] = '{2, 1, 0, 3};
    tbl[1] = '{0, 3, 2, 1};
    tbl[2] = '{1, 0, 3, 2};
    tbl[3] = '{3, 2, 1, 0};
    for (int m = 0; m < 3; m++)
      for (int r = 0; r < 3; r++) etbl[m][r] = r;
    exp_cnt = 0;
    e_cnt   = 0;
  endtask

  function automatic logic [127:0] mperm(input logic [127:0] d, input int m, input bit inv);
    logic [31:0] ri [4];
    logic [31:0] ro [4];
    int map [4];
    logic [127:0] o;
    for (int r = 0; r < 4; r++) begin
      ri[r]  = d[r*32 +: 32];
      map[r] = (m < 4) ? tbl[m][r] : r;
      ro[r]  = '0;
    end
    if (!inv) for (int r = 0; r < 4; r++) ro[r] = ri[map[r]];
    else      for (int r = 0; r < 4; r++) ro[map[r]] = ri[r];
    for (int r = 0; r < 4; r++) o[r*32 +: 32] = ro[r];
    return o;
  endfunction

  function automatic logic [23:0] eperm(input logic [23:0] d, input int m);
    logic [23:0] o;
    for (int r = 0; r < 3; r++)
      o[r*8 +: 8] = d[((m < 3) ? etbl[m][r] : r)*8 +: 8];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 0; in_data = '0; in_mode = '0; inv_drv = 0; out_ready = 1;
    cfg_we = 0; cfg_mode = '0; cfg_row = '0; cfg_src = '0; cfg_err_clr = 0;
    e_in_valid = 0; e_in_data = '0; e_in_mode = '0; e_out_ready = 1;
    e_cfg_we = 0; e_cfg_mode = '0; e_cfg_row = '0; e_cfg_src = '0; e_cfg_err_clr = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (out_mode !== 2'd0) begin bad++; $display("FAIL reset_out_mode got=%0d want=0", out_mode); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%0b want=0", cfg_err); end
    total++; if (xfer_cnt !== 16'd0) begin bad++; $display("FAIL reset_xfer_cnt got=%0d want=0", xfer_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (e_out_valid !== 1'b0 || e_cfg_err !== 1'b0) begin bad++; $display("FAIL reset_edut got=%0b%0b want=00", e_out_valid, e_cfg_err); end
`ifdef ROW_PERMUTER_INVERSE_EN
    total++; if (out_inv !== 1'b0) begin bad++; $display("FAIL reset_out_inv got=%0b want=0", out_inv); end
`endif
    rst = 0;
    model_reset();
  endtask

  task automatic test_defaults;
    logic [127:0] got [4];
    logic [127:0] d, want;
    int m;
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_mode = 2'(k); in_data = rmat;
      want = mperm(rmat, k, 0);
      tick();
      exp_cnt++;
      got[k] = out_data;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL def_valid m=%0d got=%0b want=1", k, out_valid); end
      total++; if (out_data !== want) begin bad++; $display("FAIL def_data m=%0d got=%h want=%h", k, out_data, want); end
      total++; if (out_mode !== 2'(k)) begin bad++; $display("FAIL def_mode got=%0d want=%0d", out_mode, k); end
    end
    total++; if (got[0] !== {R3, R0, R1, R2}) begin bad++; $display("FAIL def_mode0_const got=%h want=%h", got[0], {R3, R0, R1, R2}); end
    total++; if (got[3] !== {R0, R1, R2, R3}) begin bad++; $display("FAIL def_mode3_const got=%h want=%h", got[3], {R0, R1, R2, R3}); end
    for (int k = 0; k < 16; k++) begin
      d = rnd128(); m = $urandom_range(0, 3);
      in_valid = 1; in_mode = 2'(m); in_data = d;
      want = mperm(d, m, 0);
      tick();
      exp_cnt++;
      total++; if (out_data !== want) begin bad++; $display("FAIL def_rand got=%h want=%h", out_data, want); end
    end
    in_valid = 0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL def_drain got=%0b want=0", out_valid); end
    total++; if (xfer_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL def_cnt got=%0d want=%0d", xfer_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure;
    logic [127:0] bd [3];
    logic [127:0] bw [3];
    int bm [3];
    for (int k = 0; k < 3; k++) begin
      bd[k] = rnd128(); bm[k] = $urandom_range(0, 3); bw[k] = mperm(bd[k], bm[k], 0);
    end
    out_ready = 0; in_valid = 1; in_data = bd[0]; in_mode = 2'(bm[0]);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_first_ready got=%0b want=1", in_ready); end
    tick();
    exp_cnt++;
    in_data = bd[1]; in_mode = 2'(bm[1]);
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready c=%0d got=%0b want=0", c, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== bw[0]) begin bad++; $display("FAIL bp_hold_data c=%0d got=%0b/%h want=1/%h", c, out_valid, out_data, bw[0]); end
    end
    out_ready = 1;
    for (int k = 1; k < 3; k++) begin
      in_data = bd[k]; in_mode = 2'(bm[k]);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_drain_ready k=%0d got=%0b want=1", k, in_ready); end
      tick();
      exp_cnt++;
      total++; if (out_valid !== 1'b1 || out_data !== bw[k] || out_mode !== 2'(bm[k])) begin bad++; $display("FAIL bp_drain_data k=%0d got=%h want=%h", k, out_data, bw[k]); end
    end
    in_valid = 0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b want=0", out_valid); end
    total++; if (xfer_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL bp_cnt got=%0d want=%0d", xfer_cnt, exp_cnt); end
  endtask

`ifdef ROW_PERMUTER_INVERSE_EN
  task automatic test_inverse;
    out_ready = 1; in_valid = 1; in_data = rmat; inv_drv = 1;
    in_mode = 2'd0;
    tick(); exp_cnt++;
    total++; if (out_data !== {R3, R0, R1, R2}) begin bad++; $display("FAIL inv_mode0 got=%h want=%h", out_data, {R3, R0, R1, R2}); end
    total++; if (out_inv !== 1'b1) begin bad++; $display("FAIL inv_flag got=%0b want=1", out_inv); end
    in_mode = 2'd1;
    tick(); exp_cnt++;
    total++; if (out_data !== {R1, R2, R3, R0}) begin bad++; $display("FAIL inv_mode1 got=%h want=%h", out_data, {R1, R2, R3, R0}); end
    total++; if (out_data !== mperm(rmat, 1, 1)) begin bad++; $display("FAIL inv_model got=%h want=%h", out_data, mperm(rmat, 1, 1)); end
    inv_drv = 0; in_valid = 0;
    tick();
  endtask
`endif

  task automatic test_cfg_write;
    logic [127:0] first, want;
    out_ready = 1;
    for (int r = 0; r < 4; r++) begin
      cfg_we = 1; cfg_mode = 2'd1; cfg_row = 2'(r); cfg_src = 2'd3;
      in_valid = 1; in_mode = 2'd1; in_data = rmat;
      want = mperm(rmat, 1, 0);
      tick();
      tbl[1][r] = 3; exp_cnt++;
      if (r == 0) first = out_data;
      total++; if (out_data !== want) begin bad++; $display("FAIL cfg_step r=%0d got=%h want=%h", r, out_data, want); end
    end
    cfg_we = 0;
    tick(); exp_cnt++;
    total++; if (first !== {R1, R2, R3, R0}) begin bad++; $display("FAIL cfg_old_table got=%h want=%h", first, {R1, R2, R3, R0}); end
    total++; if (out_data !== {R3, R3, R3, R3}) begin bad++; $display("FAIL cfg_new_table got=%h want=%h", out_data, {R3, R3, R3, R3}); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_no_err got=%0b want=0", cfg_err); end
    in_valid = 0;
    tick();
  endtask

  task automatic test_back_to_back;
    bit exp_ov, exp_rdy, acc, exp_inv, nd_inv;
    logic [127:0] exp_data, nd;
    logic [1:0] exp_mode;
    int m;
    exp_ov = 0; exp_data = '0; exp_mode = '0; exp_inv = 0;
    for (int c = 0; c < 300; c++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_data = rnd128(); m = $urandom_range(0, 3); in_mode = 2'(m);
`ifdef ROW_PERMUTER_INVERSE_EN
      inv_drv = $urandom % 2;
`else
      inv_drv = 0;
`endif
      cfg_we = ($urandom % 8) == 0;
      cfg_mode = 2'($urandom); cfg_row = 2'($urandom); cfg_src = 2'($urandom);
      #1;
      exp_rdy = !exp_ov || out_ready;
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready c=%0d got=%0b want=%0b", c, in_ready, exp_rdy); end
      acc = in_valid && exp_rdy;
      nd = mperm(in_data, m, inv_drv); nd_inv = inv_drv;
      tick();
      if (cfg_we) tbl[cfg_mode][cfg_row] = int'(cfg_src);
      if (acc) begin
        exp_ov = 1; exp_data = nd; exp_mode = 2'(m); exp_inv = nd_inv; exp_cnt++;
      end else if (out_ready) begin
        exp_ov = 0;
      end
      total++; if (out_valid !== exp_ov) begin bad++; $display("FAIL b2b_valid c=%0d got=%0b want=%0b", c, out_valid, exp_ov); end
      if (exp_ov) begin
        total++; if (out_data !== exp_data || out_mode !== exp_mode) begin bad++; $display("FAIL b2b_data c=%0d got=%h/%0d want=%h/%0d", c, out_data, out_mode, exp_data, exp_mode); end
`ifdef ROW_PERMUTER_INVERSE_EN
        total++; if (out_inv !== exp_inv) begin bad++; $display("FAIL b2b_inv c=%0d got=%0b want=%0b", c, out_inv, exp_inv); end
`endif
      end
    end
    idle();
    tick();
    total++; if (xfer_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL b2b_cnt got=%0d want=%0d", xfer_cnt, exp_cnt); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%0b want=0", cfg_err); end
  endtask

  task automatic test_reset_mid;
    idle();
    out_ready = 0;
    cfg_we = 1; cfg_mode = 2'd0; cfg_row = 2'd0; cfg_src = 2'd3;
    in_valid = 1; in_mode = 2'd0; in_data = rmat;
    tick();
    cfg_we = 0; in_valid = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%0b want=1", out_valid); end
    #2;
    rst = 1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_async_valid got=%0b want=0", out_valid); end
    total++; if (xfer_cnt !== 16'd0) begin bad++; $display("FAIL rmid_cnt got=%0d want=0", xfer_cnt); end
    @(negedge clk);
    rst = 0;
    model_reset();
    out_ready = 1; in_valid = 1; in_mode = 2'd0; in_data = rmat;
    tick(); exp_cnt++;
    total++; if (out_data !== {R3, R0, R1, R2}) begin bad++; $display("FAIL rmid_default got=%h want=%h", out_data, {R3, R0, R1, R2}); end
    in_valid = 0;
    tick();
  endtask

  task automatic test_errors;
    logic [23:0] d, want;
    int m;
    idle();
    // source row out of range
    e_cfg_we = 1; e_cfg_mode = 2'd0; e_cfg_row = 2'd0; e_cfg_src = 2'd3;
    tick(); e_cfg_we = 0;
    total++; if (e_cfg_err !== 1'b1) begin bad++; $display("FAIL err_src got=%0b want=1", e_cfg_err); end
    d = 24'($urandom); e_in_valid = 1; e_in_mode = 2'd0; e_in_data = d;
    tick(); e_in_valid = 0; e_cnt++;
    total++; if (e_out_data !== d) begin bad++; $display("FAIL err_src_unchanged got=%h want=%h", e_out_data, d); end
    e_cfg_err_clr = 1; tick(); e_cfg_err_clr = 0;
    total++; if (e_cfg_err !== 1'b0) begin bad++; $display("FAIL err_clr got=%0b want=0", e_cfg_err); end
    // row out of range
    e_cfg_we = 1; e_cfg_row = 2'd3; e_cfg_src = 2'd1;
    tick(); e_cfg_we = 0;
    total++; if (e_cfg_err !== 1'b1) begin bad++; $display("FAIL err_row got=%0b want=1", e_cfg_err); end
    e_cfg_err_clr = 1; tick(); e_cfg_err_clr = 0;
    // mode out of range
    e_cfg_we = 1; e_cfg_mode = 2'd3; e_cfg_row = 2'd0; e_cfg_src = 2'd1;
    tick(); e_cfg_we = 0;
    total++; if (e_cfg_err !== 1'b1) begin bad++; $display("FAIL err_mode got=%0b want=1", e_cfg_err); end
    e_cfg_err_clr = 1; tick(); e_cfg_err_clr = 0;
    // beat with out-of-range mode uses identity
    d = 24'($urandom); e_in_valid = 1; e_in_mode = 2'd3; e_in_data = d;
    tick(); e_in_valid = 0; e_cnt++;
    total++; if (e_out_data !== d || e_out_mode !== 2'd3) begin bad++; $display("FAIL err_inmode got=%h/%0d want=%h/3", e_out_data, e_out_mode, d); end
    total++; if (e_cfg_err !== 1'b1) begin bad++; $display("FAIL err_inmode_flag got=%0b want=1", e_cfg_err); end
    // set and clear together: set wins
    e_cfg_err_clr = 1; tick();
    e_cfg_we = 1; e_cfg_mode = 2'd0; e_cfg_row = 2'd0; e_cfg_src = 2'd3;
    tick(); e_cfg_we = 0; e_cfg_err_clr = 0;
    total++; if (e_cfg_err !== 1'b1) begin bad++; $display("FAIL err_set_wins got=%0b want=1", e_cfg_err); end
    e_cfg_err_clr = 1; tick(); e_cfg_err_clr = 0;
    // valid write creates a duplicate row
    e_cfg_we = 1; e_cfg_mode = 2'd2; e_cfg_row = 2'd0; e_cfg_src = 2'd2;
    tick(); e_cfg_we = 0; etbl[2][0] = 2;
    total++; if (e_cfg_err !== 1'b0) begin bad++; $display("FAIL err_valid_write got=%0b want=0", e_cfg_err); end
    d = 24'($urandom); e_in_valid = 1; e_in_mode = 2'd2; e_in_data = d;
    tick(); e_cnt++;
    want = {d[23:16], d[15:8], d[23:16]};
    total++; if (e_out_data !== want) begin bad++; $display("FAIL err_dup got=%h want=%h", e_out_data, want); end
    // run the 4-bit counter through a wrap
    for (int k = 0; k < 20; k++) begin
      d = 24'($urandom); m = $urandom_range(0, 2);
      e_in_data = d; e_in_mode = 2'(m);
      want = eperm(d, m);
      tick(); e_cnt++;
      total++; if (e_out_data !== want) begin bad++; $display("FAIL err_rand got=%h want=%h", e_out_data, want); end
    end
    e_in_valid = 0;
    tick();
    total++; if (e_xfer_cnt !== 4'(e_cnt % 16)) begin bad++; $display("FAIL err_cnt_wrap got=%0d want=%0d", e_xfer_cnt, e_cnt % 16); end
  endtask

  initial begin
    rmat = {R3, R2, R1, R0};
    test_reset();
    test_defaults();
    test_backpressure();
`ifdef ROW_PERMUTER_INVERSE_EN
    test_inverse();
`endif
    test_cfg_write();
    test_back_to_back();
    test_reset_mid();
    test_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
